pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline sequencing controller for the 6-stage core: merges per-stage stall requests into the `stall_o[5:0]` vector, and generates the `flush_o` and `kill_o` clear strobes consumed by the pc, if_id, id_ex, ex_mem and mem_wb registers. It also sequences trap entry and `mret` (drain, then flush, then redirect) and branch redirects from EX. A stall watchdog flags a pipeline hung longer than a programmable limit.

## Interface
- `WDT_LIMIT`, 16'd1024: consecutive-stall cycles before `stall_timeout_o` fires; 0 disables the watchdog.
- `clk_i`  in  1  core clock.
- `n_rst_i`  in  1  reset, synchronous, active-high (`RstEnable` = 1'b1).
- `stallreq_if_i`  in  1  fetch waiting on instruction bus.
- `stallreq_id_i`  in  1  load-use hazard.
- `stallreq_ex_i`  in  1  multicycle ALU op (div/mul) busy.
- `stallreq_mem_i`  in  1  data bus transaction outstanding.
- `branch_i`  in  1  EX resolved a taken branch or jump / mispredict.
- `branch_target_i`  in  32  redirect pc for `branch_i`.
- `exception_i`  in  32  MEM-stage exception vector; nonzero means trap.
- `mem_pc_i`  in  32  pc of the MEM-stage instruction.
- `mret_i`  in  1  MEM-stage instruction is `mret`.
- `mtvec_i`, `mepc_i`  in  32 each  CSR trap vector and return pc.
- `stall_o`  out  6  bit k=1 holds stage k (0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb).
- `flush_o`  out  1  clear all pipeline registers.
- `kill_o`  out  1  clear if_id and id_ex only (branch shadow).
- `redirect_o`  out  1  pc loads `redirect_pc_o` this cycle.
- `redirect_pc_o`  out  32  new pc.
- `trap_we_o`  out  1  one-cycle strobe: CSR unit writes mepc/mcause.
- `trap_epc_o`, `trap_cause_o`  out  32 each  values for `trap_we_o`.
- `stall_timeout_o`  out  1  sticky watchdog flag.

## Operation
- States: S_RUN, S_DRAIN, S_FLUSH. Registered: state, latched target (32), latched epc/cause (32+32), is_trap bit, watchdog counter (16), timeout flag.
- Stall vector in S_RUN, highest requester wins: mem -> 6'b011111; ex -> 6'b001111; id -> 6'b000111; if -> 6'b000011; none -> 6'b000000.
- Trap/mret detect in S_RUN when `exception_i != 0` or `mret_i`. This takes priority over `branch_i` and over stall requests from lower stages.
  - Latch target: `mtvec_i` for an exception, `mepc_i` for mret. Latch `trap_epc_o = mem_pc_i`, `trap_cause_o = exception_i`, is_trap = exception.
  - Exception has priority when `exception_i` and `mret_i` are both set.
  - Drive `stall_o` = 6'b011111 this cycle.
  - Next state: S_DRAIN if `stallreq_mem_i`, else S_FLUSH.
- S_DRAIN: `stall_o` = 6'b011111; all inputs except `stallreq_mem_i` ignored. Moves to S_FLUSH the cycle after `stallreq_mem_i` is seen low.
- S_FLUSH, one cycle:
  - `flush_o` = 1, `redirect_o` = 1, `redirect_pc_o` = latched target, `stall_o` = 0.
  - `trap_we_o` = is_trap.
  - Next state S_RUN.
- Branch, in S_RUN with no trap/mret, honoured only when `stall_o[3]` = 0: `kill_o` = 1, `redirect_o` = 1, `redirect_pc_o = branch_target_i`.
  - While EX is held, EX keeps `branch_i` asserted; the redirect happens in the first cycle EX is released.
  - Branch with `stallreq_if_i` set: redirect still issued, `stall_o` = 6'b000000.
- Watchdog:
  - Counts each cycle with `stall_o != 0`; clears on any cycle with `stall_o == 0` or in S_FLUSH.
  - At count == `WDT_LIMIT` (limit nonzero), `stall_timeout_o` sets and stays set until reset.
  - Counter saturates.

## Timing
- Stall, kill, flush and redirect outputs are combinational from the current inputs and registered state; pipeline registers and pc sample them on the same edge.
- Reset values: state S_RUN, `stall_o` 0, `flush_o` 0, `kill_o` 0, `redirect_o` 0, `redirect_pc_o` 0, `trap_we_o` 0, `trap_epc_o` 0, `trap_cause_o` 0, counter 0, `stall_timeout_o` 0.
- Outputs read reset values while `n_rst_i` is high.
- Trap latency with `stallreq_mem_i` low: detect in cycle N, flush/redirect in N+1.
- Trap latency with memory busy through cycle M: flush in M+2.
- Branch latency: redirect in the same cycle `branch_i` is honoured.
- Reset asserted in S_DRAIN or S_FLUSH: returns to S_RUN on the next edge with no flush or strobe issued.
- A new exception during S_DRAIN or S_FLUSH is ignored; the flush clears it.

## Test plan
- `stallreq_ex_i`=1 for 3 cycles, then `stallreq_id_i`=1 for 1 cycle -> `stall_o` 001111 x3, then 000111, then 000000; no flush.
- `exception_i`=32'h2, `mem_pc_i`=32'h100, `mtvec_i`=32'h80, mem idle -> cycle N `stall_o` 011111. Cycle N+1: `flush_o`=1, `redirect_pc_o`=32'h80, `trap_we_o`=1, `trap_epc_o`=32'h100, `trap_cause_o`=32'h2.
- Same trap with `stallreq_mem_i` high 4 cycles -> S_DRAIN for 4 cycles with `stall_o` 011111, then a single flush cycle.
- `branch_i`=1, target 32'h200, with `stallreq_mem_i`=1 for 2 cycles -> no redirect for 2 cycles, then `kill_o`=1, `redirect_pc_o`=32'h200. Same cycle `exception_i`≠0 and `branch_i` -> trap path wins, no kill.
- `mret_i`, `mepc_i`=32'h340 -> flush, `redirect_pc_o`=32'h340, `trap_we_o`=0.
- `WDT_LIMIT`=4, `stallreq_if_i` held -> `stall_timeout_o` rises after 4 stalled cycles and stays set after the stall clears. Reset pulsed in S_DRAIN -> S_RUN, no `flush_o`.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the 6-stage core.
// Merges per-stage stall requests, issues flush/kill strobes, sequences
// trap entry and mret (drain -> flush -> redirect), handles EX branch
// redirects and runs a sticky stall watchdog.
module pipe_ctrl #(
    parameter logic [15:0] WDT_LIMIT = 16'd1024
) (
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic        stallreq_if_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] exception_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mret_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic        kill_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        trap_we_o,
    output logic [31:0] trap_epc_o,
    output logic [31:0] trap_cause_o,
    output logic        stall_timeout_o
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] target_q;
    logic [31:0] epc_q;
    logic [31:0] cause_q;
    logic        is_trap_q;
    logic [15:0] wdt_cnt_q, wdt_cnt_d;
    logic        timeout_q, timeout_d;
    logic        trap_det;
    logic        has_exc;

    assign has_exc = (exception_i != 32'd0);

    // Next state and combinational pipeline control; everything reads reset values in reset.
    always_comb begin
        state_d       = state_q;
        trap_det      = 1'b0;
        stall_o       = 6'b000000;
        flush_o       = 1'b0;
        kill_o        = 1'b0;
        redirect_o    = 1'b0;
        redirect_pc_o = 32'd0;
        trap_we_o     = 1'b0;
        case (state_q)
            S_RUN: begin
                if (has_exc || mret_i) begin
                    // Trap/mret outranks branches and lower-stage stalls.
                    trap_det = 1'b1;
                    stall_o  = 6'b011111;
                    state_d  = stallreq_mem_i ? S_DRAIN : S_FLUSH;
                end else begin
                    if (stallreq_mem_i)     stall_o = 6'b011111;
                    else if (stallreq_ex_i) stall_o = 6'b001111;
                    else if (stallreq_id_i) stall_o = 6'b000111;
                    else if (stallreq_if_i) stall_o = 6'b000011;
                    // EX keeps branch_i high while held, so only act once EX is free.
                    if (branch_i && !stall_o[3]) begin
                        kill_o        = 1'b1;
                        redirect_o    = 1'b1;
                        redirect_pc_o = branch_target_i;
                        stall_o       = 6'b000000;
                    end
                end
            end
            S_DRAIN: begin
                stall_o = 6'b011111;
                if (!stallreq_mem_i) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                flush_o       = 1'b1;
                redirect_o    = 1'b1;
                redirect_pc_o = target_q;
                trap_we_o     = is_trap_q;
                state_d       = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
        if (n_rst_i) begin
            stall_o       = 6'b000000;
            flush_o       = 1'b0;
            kill_o        = 1'b0;
            redirect_o    = 1'b0;
            redirect_pc_o = 32'd0;
            trap_we_o     = 1'b0;
        end
    end

    // Watchdog next state: saturating stall-cycle counter and sticky flag.
    always_comb begin
        wdt_cnt_d = wdt_cnt_q;
        timeout_d = timeout_q;
        if (stall_o == 6'b000000 || state_q == S_FLUSH) begin
            wdt_cnt_d = 16'd0;
        end else if (wdt_cnt_q != 16'hffff) begin
            wdt_cnt_d = wdt_cnt_q + 16'd1;
        end
        if (WDT_LIMIT != 16'd0 && wdt_cnt_d == WDT_LIMIT) timeout_d = 1'b1;
    end

    // State, latched trap context and watchdog registers.
    always_ff @(posedge clk_i) begin
        if (n_rst_i) begin
            state_q   <= S_RUN;
            target_q  <= 32'd0;
            epc_q     <= 32'd0;
            cause_q   <= 32'd0;
            is_trap_q <= 1'b0;
            wdt_cnt_q <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wdt_cnt_q <= wdt_cnt_d;
            timeout_q <= timeout_d;
            if (trap_det) begin
                // Exception wins over a simultaneous mret.
                target_q  <= has_exc ? mtvec_i : mepc_i;
                epc_q     <= mem_pc_i;
                cause_q   <= exception_i;
                is_trap_q <= has_exc;
            end
        end
    end

    assign trap_epc_o      = n_rst_i ? 32'd0 : epc_q;
    assign trap_cause_o    = n_rst_i ? 32'd0 : cause_q;
    assign stall_timeout_o = n_rst_i ? 1'b0 : timeout_q;

endmodule
